// File: rtl/axi_lite_arbiter_2to1_if.sv
// AXI4-Lite interface bundle shared by the upstream masters and the
// downstream slave of the 2:1 arbiter. No clock or reset inside: the
// arbiter and its neighbours share aclk/aresetn at module level.
interface axi_lite_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // write address channel
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  // write data channel
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  // write response channel
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  // read address channel
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  // read data channel
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input  awready,
    output wdata, wstrb, wvalid,    input  wready,
    input  bresp, bvalid,           output bready,
    output araddr, arprot, arvalid, input  arready,
    input  rdata, rresp, rvalid,    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,    output wready,
    output bresp, bvalid,           input  bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid,    input  rready
  );
endinterface

// File: rtl/axi_lite_arbiter_2to1.sv
// Two-master to one-slave AXI4-Lite arbiter. One transaction (write or
// read) is outstanding at a time; masters are granted round-robin per
// transaction. The arbitration decision only looks at registered state and
// the upstream valids, so nothing downstream can combinationally steer it.
module axi_lite_arbiter_2to1 #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic       aclk,
  input  logic       aresetn,
  axi_lite_if.slave  s0,
  axi_lite_if.slave  s1,
  axi_lite_if.master m,
  output logic       busy,
  output logic       grant_idx
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    WR_RESP = 3'd2,
    READ    = 3'd3,
    RD_DATA = 3'd4
  } state_t;

  // registered state
  state_t state_r;
  logic   last_grant_r;
  logic   grant_idx_r;
  logic   aw_done_r;
  logic   w_done_r;
  logic   busy_r;

  // next-state values
  state_t state_next_s;
  logic   last_grant_next_s;
  logic   grant_idx_next_s;
  logic   aw_done_next_s;
  logic   w_done_next_s;

  // arbitration helpers
  logic   req0_s;
  logic   req1_s;
  logic   win_aw_s;

  // request fields of the granted master
  logic [ADDR_WIDTH-1:0] sel_awaddr_s;
  logic [2:0]            sel_awprot_s;
  logic                  sel_awvalid_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;
  logic [STRB_WIDTH-1:0] sel_wstrb_s;
  logic                  sel_wvalid_s;
  logic                  sel_bready_s;
  logic [ADDR_WIDTH-1:0] sel_araddr_s;
  logic [2:0]            sel_arprot_s;
  logic                  sel_arvalid_s;
  logic                  sel_rready_s;

  // handshakes on the downstream side
  logic aw_hs_s;
  logic w_hs_s;
  logic b_hs_s;
  logic ar_hs_s;
  logic r_hs_s;

  // responses destined for the granted master
  logic                  g_awready_s;
  logic                  g_wready_s;
  logic                  g_arready_s;
  logic                  g_bvalid_s;
  logic [1:0]            g_bresp_s;
  logic                  g_rvalid_s;
  logic [DATA_WIDTH-1:0] g_rdata_s;
  logic [1:0]            g_rresp_s;

  assign busy      = busy_r;
  assign grant_idx = grant_idx_r;

  // a port requests when it presents either an address write or read
  always_comb begin
    req0_s = s0.awvalid | s0.arvalid;
    req1_s = s1.awvalid | s1.arvalid;
  end

  // mux the request-side fields of the currently granted master
  always_comb begin
    if (grant_idx_r == 1'b1) begin
      sel_awaddr_s  = s1.awaddr;
      sel_awprot_s  = s1.awprot;
      sel_awvalid_s = s1.awvalid;
      sel_wdata_s   = s1.wdata;
      sel_wstrb_s   = s1.wstrb;
      sel_wvalid_s  = s1.wvalid;
      sel_bready_s  = s1.bready;
      sel_araddr_s  = s1.araddr;
      sel_arprot_s  = s1.arprot;
      sel_arvalid_s = s1.arvalid;
      sel_rready_s  = s1.rready;
    end else begin
      sel_awaddr_s  = s0.awaddr;
      sel_awprot_s  = s0.awprot;
      sel_awvalid_s = s0.awvalid;
      sel_wdata_s   = s0.wdata;
      sel_wstrb_s   = s0.wstrb;
      sel_wvalid_s  = s0.wvalid;
      sel_bready_s  = s0.bready;
      sel_araddr_s  = s0.araddr;
      sel_arprot_s  = s0.arprot;
      sel_arvalid_s = s0.arvalid;
      sel_rready_s  = s0.rready;
    end
  end

  // downstream handshakes, qualified by state and per-channel done flags
  always_comb begin
    aw_hs_s = (state_r == WRITE) && !aw_done_r && sel_awvalid_s && m.awready;
    w_hs_s  = (state_r == WRITE) && !w_done_r  && sel_wvalid_s  && m.wready;
    b_hs_s  = (state_r == WR_RESP) && m.bvalid && sel_bready_s;
    ar_hs_s = (state_r == READ)    && sel_arvalid_s && m.arready;
    r_hs_s  = (state_r == RD_DATA) && m.rvalid && sel_rready_s;
  end

  // state register with synchronous active-low reset
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      grant_idx_r  <= 1'b0;
      aw_done_r    <= 1'b0;
      w_done_r     <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      last_grant_r <= last_grant_next_s;
      grant_idx_r  <= grant_idx_next_s;
      aw_done_r    <= aw_done_next_s;
      w_done_r     <= w_done_next_s;
      busy_r       <= (state_next_s != IDLE);
    end
  end

  // next-state logic: round-robin grant in IDLE, channel tracking after
  always_comb begin
    state_next_s      = state_r;
    last_grant_next_s = last_grant_r;
    grant_idx_next_s  = grant_idx_r;
    aw_done_next_s    = aw_done_r;
    w_done_next_s     = w_done_r;
    win_aw_s          = 1'b0;
    case (state_r)
      IDLE: begin
        aw_done_next_s = 1'b0;
        w_done_next_s  = 1'b0;
        if (req0_s || req1_s) begin
          if (req0_s && req1_s) begin
            grant_idx_next_s = ~last_grant_r;
          end else if (req1_s) begin
            grant_idx_next_s = 1'b1;
          end else begin
            grant_idx_next_s = 1'b0;
          end
          // a write wins over a read presented by the same port
          if (grant_idx_next_s == 1'b1) begin
            win_aw_s = s1.awvalid;
          end else begin
            win_aw_s = s0.awvalid;
          end
          if (win_aw_s) begin
            state_next_s = WRITE;
          end else begin
            state_next_s = READ;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      WRITE: begin
        if ((aw_done_r || aw_hs_s) && (w_done_r || w_hs_s)) begin
          state_next_s   = WR_RESP;
          aw_done_next_s = 1'b0;
          w_done_next_s  = 1'b0;
        end else begin
          aw_done_next_s = aw_done_r | aw_hs_s;
          w_done_next_s  = w_done_r  | w_hs_s;
        end
      end
      WR_RESP: begin
        if (b_hs_s) begin
          state_next_s      = IDLE;
          last_grant_next_s = grant_idx_r;
        end else begin
          state_next_s = WR_RESP;
        end
      end
      READ: begin
        if (ar_hs_s) begin
          state_next_s = RD_DATA;
        end else begin
          state_next_s = READ;
        end
      end
      RD_DATA: begin
        if (r_hs_s) begin
          state_next_s      = IDLE;
          last_grant_next_s = grant_idx_r;
        end else begin
          state_next_s = RD_DATA;
        end
      end
      default: begin
        state_next_s   = IDLE;
        aw_done_next_s = 1'b0;
        w_done_next_s  = 1'b0;
      end
    endcase
  end

  // output logic toward the slave and the granted-master response bundle
  always_comb begin
    m.awaddr    = {ADDR_WIDTH{1'b0}};
    m.awprot    = 3'b000;
    m.awvalid   = 1'b0;
    m.wdata     = {DATA_WIDTH{1'b0}};
    m.wstrb     = {STRB_WIDTH{1'b0}};
    m.wvalid    = 1'b0;
    m.bready    = 1'b0;
    m.araddr    = {ADDR_WIDTH{1'b0}};
    m.arprot    = 3'b000;
    m.arvalid   = 1'b0;
    m.rready    = 1'b0;
    g_awready_s = 1'b0;
    g_wready_s  = 1'b0;
    g_arready_s = 1'b0;
    g_bvalid_s  = 1'b0;
    g_bresp_s   = 2'b00;
    g_rvalid_s  = 1'b0;
    g_rdata_s   = {DATA_WIDTH{1'b0}};
    g_rresp_s   = 2'b00;
    case (state_r)
      WRITE: begin
        m.awaddr    = sel_awaddr_s;
        m.awprot    = sel_awprot_s;
        m.wdata     = sel_wdata_s;
        m.wstrb     = sel_wstrb_s;
        // a completed channel is silenced on both sides until WR_RESP
        m.awvalid   = sel_awvalid_s & ~aw_done_r;
        m.wvalid    = sel_wvalid_s  & ~w_done_r;
        g_awready_s = m.awready & ~aw_done_r;
        g_wready_s  = m.wready  & ~w_done_r;
      end
      WR_RESP: begin
        m.bready   = sel_bready_s;
        g_bvalid_s = m.bvalid;
        g_bresp_s  = m.bresp;
      end
      READ: begin
        m.araddr    = sel_araddr_s;
        m.arprot    = sel_arprot_s;
        m.arvalid   = sel_arvalid_s;
        g_arready_s = m.arready;
      end
      RD_DATA: begin
        m.rready   = sel_rready_s;
        g_rvalid_s = m.rvalid;
        g_rdata_s  = m.rdata;
        g_rresp_s  = m.rresp;
      end
      default: begin
        m.awvalid = 1'b0;
      end
    endcase
  end

  // route responses to the granted master; the other one sees all zeros
  always_comb begin
    s0.awready = 1'b0;
    s0.wready  = 1'b0;
    s0.arready = 1'b0;
    s0.bvalid  = 1'b0;
    s0.bresp   = 2'b00;
    s0.rvalid  = 1'b0;
    s0.rdata   = {DATA_WIDTH{1'b0}};
    s0.rresp   = 2'b00;
    s1.awready = 1'b0;
    s1.wready  = 1'b0;
    s1.arready = 1'b0;
    s1.bvalid  = 1'b0;
    s1.bresp   = 2'b00;
    s1.rvalid  = 1'b0;
    s1.rdata   = {DATA_WIDTH{1'b0}};
    s1.rresp   = 2'b00;
    if (grant_idx_r == 1'b1) begin
      s1.awready = g_awready_s;
      s1.wready  = g_wready_s;
      s1.arready = g_arready_s;
      s1.bvalid  = g_bvalid_s;
      s1.bresp   = g_bresp_s;
      s1.rvalid  = g_rvalid_s;
      s1.rdata   = g_rdata_s;
      s1.rresp   = g_rresp_s;
    end else begin
      s0.awready = g_awready_s;
      s0.wready  = g_wready_s;
      s0.arready = g_arready_s;
      s0.bvalid  = g_bvalid_s;
      s0.bresp   = g_bresp_s;
      s0.rvalid  = g_rvalid_s;
      s0.rdata   = g_rdata_s;
      s0.rresp   = g_rresp_s;
    end
  end

endmodule
